// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states and grant ids.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between the fetch (IF) and data (DM) ports.
// Build option: MEM_ARB_RR_EN selects round-robin on contention; otherwise
// DM always beats IF so the older instruction in MEM is never starved.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
`ifdef MEM_ARB_RR_EN
  input  logic last_gnt,
`endif
  output logic gnt
);

  // Pick the winner; the value only matters when at least one port requests
  always_comb begin
    gnt = GNT_DM;
`ifdef MEM_ARB_RR_EN
    if (if_req && dm_req) begin
      gnt = ~last_gnt;
    end else if (if_req) begin
      gnt = GNT_IF;
    end
`else
    if (if_req && !dm_req) begin
      gnt = GNT_IF;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported, fixed-latency memory between the IF and DM ports.
// One access at a time: IDLE grants and latches the command, ACCESS holds it
// for LAT cycles and captures read data, DONE pulses the granted ack.
// All outputs are registered. Build option: MEM_ARB_RR_EN (round-robin).
// LAT must be at least 1.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(LAT) + 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          gnt;
  // Grant of the current/most recent access; doubles as the round-robin
  // last-grant flag when that option is built in.
  logic          gnt_q;

  mem_arb_pick u_pick (
    .if_req   (if_req),
    .dm_req   (dm_req),
`ifdef MEM_ARB_RR_EN
    .last_gnt (gnt_q),
`endif
    .gnt      (gnt)
  );

  // Access sequencer: grant and latch, hold the command LAT cycles, pulse ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      gnt_q     <= GNT_IF;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (if_req || dm_req) begin
            gnt_q  <= gnt;
            cnt    <= CW'(LAT - 1);
            mem_en <= 1'b1;
            state  <= ST_ACCESS;
            if (gnt == GNT_DM) begin
              mem_addr  <= dm_addr;
              mem_we    <= dm_we;
              mem_wdata <= dm_wdata;
            end else begin
              // Fetches are always reads; write data is left as it was
              mem_addr <= if_addr;
              mem_we   <= 1'b0;
            end
          end
        end

        ST_ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            // mem_rdata is valid only in this last command cycle
            if (!mem_we) begin
              if (gnt_q == GNT_DM) begin
                dm_rdata <= mem_rdata;
              end else begin
                if_rdata <= mem_rdata;
              end
            end
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (gnt_q == GNT_DM) begin
              dm_ack <= 1'b1;
            end else begin
              if_ack <= 1'b1;
            end
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Requests are ignored here so a requester has a cycle to drop
          if_ack <= 1'b0;
          dm_ack <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-level timing model.
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam bit P_IF = 1'b0;
  localparam bit P_DM = 1'b1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          rst1 = 1'b1;
  logic          if_req1 = 1'b0;
  logic [AW-1:0] if_addr1 = '0;
  logic          if_ack1;
  logic [DW-1:0] if_rdata1;
  logic          dm_ack1;
  logic [DW-1:0] dm_rdata1;
  logic          mem_en1;
  logic          mem_we1;
  logic [AW-1:0] mem_addr1;
  logic [DW-1:0] mem_wdata1;
  logic [DW-1:0] mem_rdata1;

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst1),
    .if_req(if_req1), .if_addr(if_addr1), .if_ack(if_ack1), .if_rdata(if_rdata1),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr('0), .dm_wdata('0),
    .dm_ack(dm_ack1), .dm_rdata(dm_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents as a pure function of address
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Fixed-latency memory: data is valid only in the LAT-th enabled cycle
  int en_run = 0;
  always @(posedge clk) en_run <= mem_en ? en_run + 1 : 0;
  assign mem_rdata  = (mem_en && en_run == LAT - 1) ? mem_word(mem_addr) : ~mem_word(mem_addr);
  assign mem_rdata1 = mem_en1 ? mem_word(mem_addr1) : (~mem_word(mem_addr1) ^ mem_wdata1);

  // Reference model: the one outstanding access and expected rdata registers
  bit            t_valid = 1'b0;
  int            t_start = 0;
  bit            t_port = P_IF;
  bit            t_we = 1'b0;
  logic [AW-1:0] t_addr = '0;
  logic [DW-1:0] t_wdata = '0;
  logic [DW-1:0] e_if_rd = '0;
  logic [DW-1:0] e_dm_rd = '0;
`ifdef MEM_ARB_RR_EN
  bit            last_gnt = P_IF;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  bit            rst_cmd = 1'b1;
  bit            rand_on = 1'b0;
  bit            cont_if = 1'b0;
  bit            cont_dm = 1'b0;
  bit            go_if = 1'b0;
  bit            go_dm = 1'b0;
  logic [AW-1:0] go_if_addr = '0;
  logic [AW-1:0] go_dm_addr = '0;
  logic          go_dm_we = 1'b0;
  logic [DW-1:0] go_dm_wdata = '0;
  int            if_ack_cyc = -100;
  int            dm_ack_cyc = -100;
  int            if_ack_n = 0;
  int            en_obs = 0;
  bit            ack_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return $urandom;
  endfunction

  // One cycle: check outputs, update requesters, advance the model
  task automatic step();
    bit in_acc;
    bit ack_c;
    bit pick;
    @(negedge clk);
    in_acc = t_valid && cyc >= t_start + 1 && cyc <= t_start + LAT;
    ack_c  = t_valid && cyc == t_start + LAT + 1;
    if (ack_c && !t_we) begin
      if (t_port == P_IF) e_if_rd = mem_word(t_addr);
      else                e_dm_rd = mem_word(t_addr);
    end
    chk("mem_en", 32'(mem_en), 32'(in_acc));
    chk("mem_we", 32'(mem_we), 32'(in_acc && t_we));
    if (in_acc) chk("mem_addr", mem_addr, t_addr);
    if (in_acc && t_we) chk("mem_wdata", mem_wdata, t_wdata);
    chk("if_ack", 32'(if_ack), 32'(ack_c && t_port == P_IF));
    chk("dm_ack", 32'(dm_ack), 32'(ack_c && t_port == P_DM));
    chk("if_rdata", if_rdata, e_if_rd);
    chk("dm_rdata", dm_rdata, e_dm_rd);

    if (mem_en) en_obs++;
    if (if_ack) begin if_ack_cyc = cyc; if_ack_n++; ack_q.push_back(P_IF); end
    if (dm_ack) begin dm_ack_cyc = cyc; ack_q.push_back(P_DM); end

    rst = rst_cmd;
    if (ack_c && t_port == P_IF) begin
      if (cont_if) if_addr = rnd_addr();
      else         if_req = 1'b0;
    end
    if (ack_c && t_port == P_DM) begin
      if (cont_dm) dm_addr = rnd_addr();
      else         dm_req = 1'b0;
    end
    if (rand_on && in_acc && $urandom_range(99) < 2) begin
      if (t_port == P_IF) if_req = 1'b0;
      else                dm_req = 1'b0;
    end
    if (go_if) begin
      if_req = 1'b1; if_addr = go_if_addr; go_if = 1'b0;
    end else if (rand_on && !if_req && $urandom_range(99) < 30) begin
      if_req = 1'b1; if_addr = rnd_addr();
    end
    if (go_dm) begin
      dm_req = 1'b1; dm_addr = go_dm_addr; dm_we = go_dm_we; dm_wdata = go_dm_wdata; go_dm = 1'b0;
    end else if (rand_on && !dm_req && $urandom_range(99) < 30) begin
      dm_req = 1'b1; dm_addr = rnd_addr(); dm_we = 1'($urandom_range(1)); dm_wdata = $urandom;
    end

    if (rst_cmd) begin
      t_valid = 1'b0;
      e_if_rd = '0;
      e_dm_rd = '0;
`ifdef MEM_ARB_RR_EN
      last_gnt = P_IF;
`endif
    end else if ((!t_valid || cyc >= t_start + LAT + 2) && (if_req || dm_req)) begin
      pick = dm_req ? P_DM : P_IF;
`ifdef MEM_ARB_RR_EN
      if (if_req && dm_req) pick = ~last_gnt;
      last_gnt = pick;
`endif
      t_valid = 1'b1;
      t_start = cyc;
      t_port  = pick;
      t_we    = (pick == P_DM) ? dm_we : 1'b0;
      t_addr  = (pick == P_DM) ? dm_addr : if_addr;
      t_wdata = dm_wdata;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((if_req || dm_req || (t_valid && cyc < t_start + LAT + 2)) && n < 300) begin
      step();
      n++;
    end
    chk("idle_wait", 32'(n < 300), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int acks0;
    int cnt;
    bit exp_p;
    logic [DW-1:0] keep;

    rst_cmd = 1'b1;
    repeat (3) step();
    rst_cmd = 1'b0;
    step();

    // IF read alone
    en_obs = 0; go_if = 1'b1; go_if_addr = 32'h10;
    step(); n0 = t_start;
    wait_idle();
    chk("if_lat", 32'(if_ack_cyc - n0), 32'(LAT + 1));
    chk("if_en_len", 32'(en_obs), 32'(LAT));
    chk("if_rdata_dir", if_rdata, 32'hDEADBEEF);

    // Simultaneous requests
    go_if = 1'b1; go_if_addr = 32'h84;
    go_dm = 1'b1; go_dm_addr = 32'h80; go_dm_we = 1'b0; go_dm_wdata = 32'h0;
    step(); n0 = t_start;
    wait_idle();
    chk("sim_dm_lat", 32'(dm_ack_cyc - n0), 32'(LAT + 1));
    chk("sim_if_lat", 32'(if_ack_cyc - n0), 32'(2 * LAT + 3));

    // DM write
    keep = dm_rdata; en_obs = 0;
    go_dm = 1'b1; go_dm_addr = 32'h40; go_dm_we = 1'b1; go_dm_wdata = 32'h12345678;
    step(); n0 = t_start;
    wait_idle();
    chk("wr_lat", 32'(dm_ack_cyc - n0), 32'(LAT + 1));
    chk("wr_en_len", 32'(en_obs), 32'(LAT));
    chk("wr_rdata_keep", dm_rdata, keep);

    // Reset in the middle of an access
    go_if = 1'b1; go_if_addr = 32'h20;
    step();
    rst_cmd = 1'b1;
    step();
    rst_cmd = 1'b0; acks0 = if_ack_n;
    step();
    chk("rst_en_low", 32'(mem_en), 32'd0);
    chk("rst_no_ack", 32'(if_ack), 32'd0);
    n0 = t_start;
    wait_idle();
    chk("rst_retry_acks", 32'(if_ack_n - acks0), 32'd1);
    chk("rst_retry_lat", 32'(if_ack_cyc - n0), 32'(LAT + 1));

    // Both ports held continuously
    ack_q.delete();
    cont_if = 1'b1; cont_dm = 1'b1;
    go_if = 1'b1; go_if_addr = 32'h100;
    go_dm = 1'b1; go_dm_addr = 32'h200; go_dm_we = 1'b0;
    step();
    cnt = 0;
    while (ack_q.size() < 4 && cnt < 100) begin step(); cnt++; end
    cont_if = 1'b0; cont_dm = 1'b0;
    wait_idle();
    chk("rr_acks", 32'(ack_q.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_p = (i % 2 == 0) ? P_DM : P_IF;
`else
      exp_p = P_DM;
`endif
      if (i < ack_q.size()) chk($sformatf("rr_gnt%0d", i), 32'(ack_q[i]), 32'(exp_p));
    end

    // Randomized traffic with occasional resets and illegal drops
    rand_on = 1'b1;
    repeat (2500) begin
      rst_cmd = ($urandom_range(399) == 0);
      step();
    end
    rst_cmd = 1'b0; rand_on = 1'b0;
    wait_idle();

    // LAT=1 instance: IF read alone
    @(negedge clk); rst1 = 1'b0;
    @(negedge clk); if_req1 = 1'b1; if_addr1 = 32'h10;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("l1_en%0d", k), 32'(mem_en1), 32'(k == 1));
      chk($sformatf("l1_ack%0d", k), 32'(if_ack1), 32'(k == 2));
      chk($sformatf("l1_we%0d", k), 32'(mem_we1), 32'd0);
      chk($sformatf("l1_dmack%0d", k), 32'(dm_ack1), 32'd0);
      if (k == 1) chk("l1_addr", mem_addr1, 32'h10);
      if (k == 2) begin
        chk("l1_rdata", if_rdata1, 32'hDEADBEEF);
        if_req1 = 1'b0;
      end
    end
    chk("l1_dm_rdata", dm_rdata1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
